// File: rtl/lcd_calc_writer.sv
// Renders "A op B = R1 [r R2]" on line 1 of an HD44780 LCD through a byte-level
// controller handshake, converting binary values to decimal with zero suppression.
module lcd_calc_writer #(
    parameter int OPW        = 8,
    parameter int RESW       = 16,
    parameter int OP_DIGITS  = 3,
    parameter int RES_DIGITS = 5,
    parameter int DLY_CYCLES = 262142
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iTrig,
    input  logic [OPW-1:0]  iA,
    input  logic [OPW-1:0]  iB,
    input  logic [1:0]      iOp,
    input  logic [RESW-1:0] iRes1,
    input  logic [RESW-1:0] iRes2,
    input  logic            iNeg1,
    output logic [7:0]      oLCD_DATA,
    output logic            oLCD_RS,
    output logic            oLCD_Start,
    input  logic            iLCD_Done,
    output logic            oBusy,
    output logic            oDoneP
);

    localparam int MAXW   = (OPW > RESW) ? OPW : RESW;
    localparam int OPBW   = 4 * OP_DIGITS;
    localparam int RESBW  = 4 * RES_DIGITS;

    // Fixed slot layout; suppressed slots are skipped at LOAD time.
    localparam int S_A     = 2;
    localparam int S_OP    = S_A + OP_DIGITS;
    localparam int S_B     = S_OP + 1;
    localparam int S_EQ    = S_B + OP_DIGITS;
    localparam int S_NEG   = S_EQ + 1;
    localparam int S_R1    = S_NEG + 1;
    localparam int S_R     = S_R1 + RES_DIGITS;
    localparam int S_R2    = S_R + 1;
    localparam int N_SLOTS = S_R2 + RES_DIGITS;

    localparam int IDXW = $clog2(N_SLOTS + 1);
    localparam int CNVW = $clog2(MAXW + 1);
    localparam int DLYW = $clog2(DLY_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, CONV, LOAD, SEND, WAIT_DONE, DELAY, NEXT, FINISH
    } state_t;

    state_t state, state_nx;

    logic [MAXW-1:0]  bin_a, bin_b, bin_r1, bin_r2;
    logic [OPBW-1:0]  bcd_a, bcd_b;
    logic [RESBW-1:0] bcd_r1, bcd_r2;
    logic [1:0]       op_q;
    logic             neg_q;
    logic [IDXW-1:0]  idx;
    logic [CNVW-1:0]  cnv_cnt;
    logic [DLYW-1:0]  dly_cnt;

    logic [OP_DIGITS-1:0]  mask_a, mask_b;
    logic [RES_DIGITS-1:0] mask_r1, mask_r2;
    logic                  slot_vld;
    logic [8:0]            slot_byte;
    logic                  last_slot;

    function automatic logic [OPBW-1:0] op_shift(input logic [OPBW-1:0] bcd, input logic b);
        logic [OPBW-1:0] t;
        t = bcd;
        for (int i = 0; i < OP_DIGITS; i++)
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        return {t[OPBW-2:0], b};
    endfunction

    function automatic logic [RESBW-1:0] res_shift(input logic [RESBW-1:0] bcd, input logic b);
        logic [RESBW-1:0] t;
        t = bcd;
        for (int i = 0; i < RES_DIGITS; i++)
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        return {t[RESBW-2:0], b};
    endfunction

    // Bit k (most-significant digit first) is set once a non-zero digit has been seen.
    function automatic logic [OP_DIGITS-1:0] op_mask(input logic [OPBW-1:0] bcd);
        logic seen;
        logic [OP_DIGITS-1:0] m;
        seen = 1'b0;
        m    = '0;
        for (int k = 0; k < OP_DIGITS; k++) begin
            seen = seen | (bcd[4*(OP_DIGITS-1-k) +: 4] != 4'd0);
            m[k] = seen | (k == OP_DIGITS - 1);
        end
        return m;
    endfunction

    function automatic logic [RES_DIGITS-1:0] res_mask(input logic [RESBW-1:0] bcd);
        logic seen;
        logic [RES_DIGITS-1:0] m;
        seen = 1'b0;
        m    = '0;
        for (int k = 0; k < RES_DIGITS; k++) begin
            seen = seen | (bcd[4*(RES_DIGITS-1-k) +: 4] != 4'd0);
            m[k] = seen | (k == RES_DIGITS - 1);
        end
        return m;
    endfunction

    assign mask_a  = op_mask(bcd_a);
    assign mask_b  = op_mask(bcd_b);
    assign mask_r1 = res_mask(bcd_r1);
    assign mask_r2 = res_mask(bcd_r2);

    always_comb begin
        slot_vld  = 1'b0;
        slot_byte = 9'h000;
        if (int'(idx) == 0) begin
            slot_vld  = 1'b1;
            slot_byte = 9'h001;
        end
        if (int'(idx) == 1) begin
            slot_vld  = 1'b1;
            slot_byte = 9'h080;
        end
        for (int k = 0; k < OP_DIGITS; k++) begin
            if (int'(idx) == S_A + k) begin
                slot_vld  = mask_a[k];
                slot_byte = {1'b1, 4'h3, bcd_a[4*(OP_DIGITS-1-k) +: 4]};
            end
            if (int'(idx) == S_B + k) begin
                slot_vld  = mask_b[k];
                slot_byte = {1'b1, 4'h3, bcd_b[4*(OP_DIGITS-1-k) +: 4]};
            end
        end
        if (int'(idx) == S_OP) begin
            slot_vld = 1'b1;
            case (op_q)
                2'd0:    slot_byte = 9'h12B;
                2'd1:    slot_byte = 9'h12D;
                2'd2:    slot_byte = 9'h12A;
                default: slot_byte = 9'h12F;
            endcase
        end
        if (int'(idx) == S_EQ) begin
            slot_vld  = 1'b1;
            slot_byte = 9'h13D;
        end
        if (int'(idx) == S_NEG) begin
            slot_vld  = neg_q;
            slot_byte = 9'h12D;
        end
        for (int k = 0; k < RES_DIGITS; k++) begin
            if (int'(idx) == S_R1 + k) begin
                slot_vld  = mask_r1[k];
                slot_byte = {1'b1, 4'h3, bcd_r1[4*(RES_DIGITS-1-k) +: 4]};
            end
            if (int'(idx) == S_R2 + k) begin
                slot_vld  = mask_r2[k] & (op_q == 2'd3);
                slot_byte = {1'b1, 4'h3, bcd_r2[4*(RES_DIGITS-1-k) +: 4]};
            end
        end
        if (int'(idx) == S_R) begin
            slot_vld  = (op_q == 2'd3);
            slot_byte = 9'h172;
        end
    end

    // The remainder section exists only for division; otherwise R1's last digit ends the line.
    assign last_slot = (int'(idx) == N_SLOTS - 1) || ((op_q != 2'd3) && (int'(idx) == S_R - 1));

    always_ff @(posedge iCLK) begin
        if (iRST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        oLCD_Start = 1'b0;
        oBusy      = 1'b1;
        oDoneP     = 1'b0;
        case (state)
            IDLE: begin
                oBusy = 1'b0;
                if (iTrig) state_nx = CONV;
            end
            CONV:      if (cnv_cnt == CNVW'(MAXW - 1)) state_nx = LOAD;
            LOAD:      if (slot_vld) state_nx = SEND;
            SEND: begin
                oLCD_Start = 1'b1;
                state_nx   = WAIT_DONE;
            end
            WAIT_DONE: begin
                oLCD_Start = 1'b1;
                if (iLCD_Done) state_nx = DELAY;
            end
            DELAY:     if (dly_cnt == DLYW'(DLY_CYCLES - 1)) state_nx = NEXT;
            NEXT:      state_nx = last_slot ? FINISH : LOAD;
            FINISH: begin
                oBusy    = 1'b0;
                oDoneP   = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                oBusy    = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bin_a     <= '0;
            bin_b     <= '0;
            bin_r1    <= '0;
            bin_r2    <= '0;
            bcd_a     <= '0;
            bcd_b     <= '0;
            bcd_r1    <= '0;
            bcd_r2    <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            idx       <= '0;
            cnv_cnt   <= '0;
            dly_cnt   <= '0;
            oLCD_DATA <= '0;
            oLCD_RS   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (iTrig) begin
                    bin_a   <= MAXW'(iA);
                    bin_b   <= MAXW'(iB);
                    bin_r1  <= MAXW'(iRes1);
                    bin_r2  <= MAXW'(iRes2);
                    bcd_a   <= '0;
                    bcd_b   <= '0;
                    bcd_r1  <= '0;
                    bcd_r2  <= '0;
                    op_q    <= iOp;
                    neg_q   <= iNeg1;
                    idx     <= '0;
                    cnv_cnt <= '0;
                    dly_cnt <= '0;
                end
                CONV: begin
                    bin_a   <= bin_a << 1;
                    bin_b   <= bin_b << 1;
                    bin_r1  <= bin_r1 << 1;
                    bin_r2  <= bin_r2 << 1;
                    bcd_a   <= op_shift(bcd_a, bin_a[MAXW-1]);
                    bcd_b   <= op_shift(bcd_b, bin_b[MAXW-1]);
                    bcd_r1  <= res_shift(bcd_r1, bin_r1[MAXW-1]);
                    bcd_r2  <= res_shift(bcd_r2, bin_r2[MAXW-1]);
                    cnv_cnt <= cnv_cnt + 1'b1;
                end
                LOAD: begin
                    if (slot_vld) {oLCD_RS, oLCD_DATA} <= slot_byte;
                    else          idx <= idx + 1'b1;
                end
                DELAY: dly_cnt <= dly_cnt + 1'b1;
                NEXT: begin
                    idx     <= idx + 1'b1;
                    dly_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_calc_writer.sv
// Randomised bench for lcd_calc_writer: an lcd controller model captures the byte
// stream, which is compared against the expression rendered with $sformatf.
module tb_lcd_calc_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic [1:0]  op = '0;
    logic [15:0] r1 = '0, r2 = '0;
    logic        neg = 1'b0;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_start, busy, done_p;
    logic        lcd_done = 1'b0;
    logic        stall = 1'b0;
    int          lcd_cnt = 0;

    int          checks = 0;
    int          failures = 0;
    int          done_total = 0;
    logic [8:0]  cap[$];
    logic [8:0]  exp_q[$];

    lcd_calc_writer #(.DLY_CYCLES(4)) dut (
        .iCLK(clk), .iRST(rst), .iTrig(trig), .iA(a), .iB(b), .iOp(op),
        .iRes1(r1), .iRes2(r2), .iNeg1(neg),
        .oLCD_DATA(lcd_data), .oLCD_RS(lcd_rs), .oLCD_Start(lcd_start),
        .iLCD_Done(lcd_done), .oBusy(busy), .oDoneP(done_p)
    );

    always #5 clk = ~clk;

    // LCD controller model: one-cycle done pulse 3 cycles after start, unless stalled.
    always @(posedge clk) begin
        if (rst) begin
            lcd_cnt  <= 0;
            lcd_done <= 1'b0;
        end else if (lcd_start && !lcd_done && !stall) begin
            if (lcd_cnt == 2) begin
                lcd_done <= 1'b1;
                lcd_cnt  <= 0;
            end else begin
                lcd_cnt <= lcd_cnt + 1;
            end
        end else begin
            lcd_done <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst && lcd_start && lcd_done) cap.push_back({lcd_rs, lcd_data});
        if (done_p) done_total <= done_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_num(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(9'h100 | 9'(s[i]));
    endtask

    task automatic build_exp(input int ta, input int tb, input int top, input int tr1,
                             input int tr2, input bit tneg);
        exp_q.delete();
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h080);
        push_num(ta);
        case (top)
            0:       exp_q.push_back(9'h12B);
            1:       exp_q.push_back(9'h12D);
            2:       exp_q.push_back(9'h12A);
            default: exp_q.push_back(9'h12F);
        endcase
        push_num(tb);
        exp_q.push_back(9'h13D);
        if (tneg) exp_q.push_back(9'h12D);
        push_num(tr1);
        if (top == 3) begin
            exp_q.push_back(9'h172);
            push_num(tr2);
        end
    endtask

    task automatic draw(input int ta, input int tb, input int top, input int tr1,
                        input int tr2, input bit tneg, input bit retrig, input string tag);
        int base, d0, lat;
        bit got;
        build_exp(ta, tb, top, tr1, tr2, tneg);
        base = cap.size();
        d0   = done_total;
        @(negedge clk);
        a = 8'(ta); b = 8'(tb); op = 2'(top); r1 = 16'(tr1); r2 = 16'(tr2); neg = tneg;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        // Disturb the inputs: the draw must use the values latched at the trigger.
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        r1 = 16'($urandom); r2 = 16'($urandom); neg = ~tneg;
        chk({tag, ":busy_after_trig"}, busy, 1);
        lat = 0;
        while (!lcd_start && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ":conv_latency"}, lat, 17);
        got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            trig = retrig && (i % 40 == 20);
            @(negedge clk);
            if (done_p) got = 1'b1;
        end
        chk({tag, ":donep_seen"}, got, 1);
        if (got) chk({tag, ":busy_at_donep"}, busy, 0);
        trig = 1'b0;
        @(negedge clk);
        chk({tag, ":busy_after"}, busy, 0);
        @(negedge clk);
        chk({tag, ":donep_count"}, done_total - d0, 1);
        chk({tag, ":byte_count"}, cap.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < cap.size())
                chk($sformatf("%s:byte%0d", tag, i), cap[base + i], exp_q[i]);
    endtask

    task automatic rand_draw(input bit retrig, input string tag);
        int ta, tb, top, tr1, tr2;
        bit tneg;
        ta  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
        tb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
        top = int'($urandom_range(0, 3));
        tr2 = 0;
        tneg = 1'b0;
        case (top)
            0: tr1 = ta + tb;
            1: begin
                tneg = (ta < tb);
                tr1  = tneg ? tb - ta : ta - tb;
            end
            2: tr1 = ta * tb;
            default: begin
                tr1 = (tb == 0) ? 0 : ta / tb;
                tr2 = (tb == 0) ? ta : ta % tb;
            end
        endcase
        draw(ta, tb, top, tr1, tr2, tneg, retrig, tag);
    endtask

    initial begin
        bit hi;
        int w;
        // Reset held 3 cycles with a trigger that must be ignored.
        rst = 1'b1;
        trig = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst:data", lcd_data, 0);
        chk("rst:rs", lcd_rs, 0);
        chk("rst:start", lcd_start, 0);
        chk("rst:busy", busy, 0);
        chk("rst:donep", done_p, 0);
        trig = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst:busy", busy, 0);

        draw(7, 5, 0, 12, 0, 1'b0, 1'b0, "t2_add");
        draw(9, 2, 3, 4, 1, 1'b0, 1'b0, "t3_div");
        draw(0, 255, 1, 255, 0, 1'b1, 1'b0, "t4_neg");
        draw(255, 255, 2, 65025, 0, 1'b0, 1'b0, "t5_mul");
        draw(100, 10, 3, 10, 0, 1'b0, 1'b1, "t6_retrig");

        // Stalled controller, then reset in the middle of the transfer.
        stall = 1'b1;
        @(negedge clk);
        a = 8'd12; b = 8'd34; op = 2'd0; r1 = 16'd46; neg = 1'b0;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        w = 0;
        while (!lcd_start && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("stall:start_seen", lcd_start, 1);
        hi = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (!lcd_start) hi = 1'b0;
        end
        chk("stall:start_held", hi, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst:start", lcd_start, 0);
        chk("midrst:busy", busy, 0);
        chk("midrst:data", lcd_data, 0);
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        draw(3, 0, 3, 0, 3, 1'b0, 1'b0, "after_rst");

        for (int n = 0; n < 10; n++) rand_draw(n[0], $sformatf("rnd%0d", n));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
